// File: rtl/bram_to_uart_tx_streamer_pkg.sv
// Shared definitions for the BRAM readback streamer and the UART-to-BRAM loader.
package bram_to_uart_tx_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int BRAM_RD_LAT    = 1;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_BYTE_CNT_W = 9;

endpackage

// File: rtl/bram_to_uart_tx_streamer.sv
// Streams 16-bit BRAM words to the UART TX byte interface, high byte first.
// IDLE: wait for command | RD: issue read | WT: capture word | HI/LO: present byte | DONE: pulse done
module bram_to_uart_tx_streamer
  import bram_to_uart_tx_streamer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BYTE_CNT_W = DEF_BYTE_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_start_addr,
  input  logic [BYTE_CNT_W-1:0] i_byte_count,
  output logic [ADDR_W-1:0]     o_addr_bram,
  output logic                  o_rd_en_bram,
  input  logic [15:0]           i_data_bram,
  output logic [7:0]            o_data_uart,
  output logic                  o_valid_uart,
  input  logic                  i_ready_uart,
  output logic                  o_busy,
  output logic                  o_done
);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [BYTE_CNT_W-1:0] cnt_q;
  logic [15:0]           word_q;
  logic                  hs;
  logic                  last_byte;

  assign hs        = o_valid_uart && i_ready_uart;
  assign last_byte = (cnt_q == BYTE_CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (i_start && (i_byte_count != '0)) begin
            addr_q <= i_start_addr;
            cnt_q  <= i_byte_count;
          end
        end
        ST_WT: word_q <= i_data_bram;
        ST_HI: begin
          if (hs) cnt_q <= cnt_q - 1'b1;
        end
        ST_LO: begin
          // Address only moves when another read follows, so the BRAM port holds steady otherwise.
          if (hs) begin
            cnt_q <= cnt_q - 1'b1;
            if (!last_byte) addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = (i_byte_count == '0) ? ST_DONE : ST_RD;
      ST_RD:   state_d = ST_WT;
      ST_WT:   state_d = ST_HI;
      ST_HI:   if (hs) state_d = last_byte ? ST_DONE : ST_LO;
      ST_LO:   if (hs) state_d = last_byte ? ST_DONE : ST_RD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_addr_bram  = addr_q;
    o_rd_en_bram = (state_q == ST_RD);
    o_valid_uart = (state_q == ST_HI) || (state_q == ST_LO);
    o_busy       = (state_q != ST_IDLE);
    o_done       = (state_q == ST_DONE);
    o_data_uart  = 8'h00;
    if (state_q == ST_HI) o_data_uart = word_q[15:8];
    else if (state_q == ST_LO) o_data_uart = word_q[7:0];
  end

endmodule
